// File: rtl/mdu_defines.sv
// Shared definitions for the multiply/divide sequencer: op codes, FSM states,
// handshake constants and the latched-operand payload.
package mdu_defines;

    localparam int unsigned MDU_OP_W = 4;
    localparam int unsigned DATA_W   = 32;

    typedef enum logic [MDU_OP_W-1:0] {
        MDU_NOP   = 4'd0,
        MDU_MULT  = 4'd1,
        MDU_MULTU = 4'd2,
        MDU_DIV   = 4'd3,
        MDU_DIVU  = 4'd4,
        MDU_MTHI  = 4'd5,
        MDU_MTLO  = 4'd6,
        MDU_MFHI  = 4'd7,
        MDU_MFLO  = 4'd8
    } mdu_op_e;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_MUL_WAIT = 2'd1,
        ST_DIV_WAIT = 2'd2,
        ST_DONE     = 2'd3
    } mdu_state_e;

    localparam logic STOP      = 1'b1;
    localparam logic NO_STOP   = 1'b0;
    localparam logic DIV_START = 1'b1;
    localparam logic DIV_STOP  = 1'b0;

    typedef struct packed {
        logic              sgn;
        logic [DATA_W-1:0] a;
        logic [DATA_W-1:0] b;
    } mdu_opnd_t;

    function automatic logic is_signed_op(input mdu_op_e op);
        return (op == MDU_MULT) || (op == MDU_DIV);
    endfunction

endpackage

// File: rtl/mdu_ctrl_hilo.sv
// Architectural HI/LO register pair: 64-bit result write, single-half writes
// and a combinational read mux.
module mdu_ctrl_hilo
    import mdu_defines::*;
(
    input  logic                clk,
    input  logic                resetn,
    input  logic                full_we,
    input  logic [2*DATA_W-1:0] full_data,
    input  logic                hi_we,
    input  logic                lo_we,
    input  logic [DATA_W-1:0]   wdata,
    input  logic                rd_hi,
    output logic [DATA_W-1:0]   hi,
    output logic [DATA_W-1:0]   lo,
    output logic [DATA_W-1:0]   rdata
);

    always_ff @(posedge clk) begin
        if (!resetn) begin
            hi <= '0;
            lo <= '0;
        end else if (full_we) begin
            hi <= full_data[2*DATA_W-1:DATA_W];
            lo <= full_data[DATA_W-1:0];
        end else begin
            if (hi_we) hi <= wdata;
            if (lo_we) lo <= wdata;
        end
    end

    assign rdata = rd_hi ? hi : lo;

endmodule

// File: rtl/mdu_ctrl.sv
// HI/LO-class instruction sequencer: drives the mul/div units, owns HI/LO and
// holds EX stalled until the result is committed.
module mdu_ctrl
    import mdu_defines::*;
#(
    parameter int unsigned MUL_LAT     = 2,
    parameter int unsigned DIV_MAX_CYC = 40
) (
    input  logic                clk,
    input  logic                resetn,
    input  logic                ex_valid,
    input  logic                ex_adv,
    input  logic                flush,
    input  logic [MDU_OP_W-1:0] mdu_op,
    input  logic [DATA_W-1:0]   src1,
    input  logic [DATA_W-1:0]   src2,
    output logic                stallreq,
    output logic [DATA_W-1:0]   mf_data,
    output logic [DATA_W-1:0]   hi_o,
    output logic [DATA_W-1:0]   lo_o,
    output logic                mdu_err,
    output logic                mul_signed,
    output logic [DATA_W-1:0]   mul_ina,
    output logic [DATA_W-1:0]   mul_inb,
    input  logic [2*DATA_W-1:0] mul_result,
    output logic                div_start,
    output logic                div_signed,
    output logic [DATA_W-1:0]   div_opdata1,
    output logic [DATA_W-1:0]   div_opdata2,
    output logic                div_annul,
    input  logic                div_ready,
    input  logic [2*DATA_W-1:0] div_result
);

    localparam int unsigned CNT_W = 3;
    localparam int unsigned WD_W  = $clog2(DIV_MAX_CYC + 1);

    mdu_state_e        state, state_nxt;
    mdu_op_e           op;
    mdu_opnd_t         opnd;
    logic [CNT_W-1:0]  cnt;
    logic [WD_W-1:0]   wd;
    logic              err;

    logic issue, op_mul, op_div, div_zero, long_issue, wd_hit, mul_done;
    logic full_we, hi_we, lo_we, rd_hi;
    logic [2*DATA_W-1:0] full_data;
    logic [DATA_W-1:0]   rdata;

    assign op         = mdu_op_e'(mdu_op);
    assign issue      = resetn && (state == ST_IDLE) && ex_valid && !flush;
    assign op_mul     = (op == MDU_MULT) || (op == MDU_MULTU);
    assign op_div     = (op == MDU_DIV) || (op == MDU_DIVU);
    assign div_zero   = (src2 == '0);
    assign long_issue = issue && (op_mul || (op_div && !div_zero));
    assign wd_hit     = (wd == WD_W'(DIV_MAX_CYC));
    assign mul_done   = (cnt == '0);

    always_ff @(posedge clk) begin
        if (!resetn) state <= ST_IDLE;
        else         state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (issue && op_mul)      state_nxt = ST_MUL_WAIT;
                else if (issue && op_div) state_nxt = div_zero ? ST_DONE : ST_DIV_WAIT;
            end
            ST_MUL_WAIT: begin
                if (flush)         state_nxt = ST_IDLE;
                else if (mul_done) state_nxt = ST_DONE;
            end
            ST_DIV_WAIT: begin
                if (flush)                    state_nxt = ST_IDLE;
                else if (div_ready || wd_hit) state_nxt = ST_DONE;
            end
            ST_DONE: begin
                if (ex_adv || flush) state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Operand latches, mul countdown, divide watchdog and sticky error.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            opnd <= '0;
            cnt  <= '0;
            wd   <= '0;
            err  <= 1'b0;
        end else begin
            if (long_issue) begin
                opnd <= '{sgn: is_signed_op(op), a: src1, b: src2};
                cnt  <= CNT_W'(MUL_LAT - 1);
                wd   <= '0;
            end
            if (state == ST_MUL_WAIT && !mul_done) cnt <= cnt - CNT_W'(1);
            if (state == ST_DIV_WAIT && !wd_hit)   wd  <= wd + WD_W'(1);
            if (state == ST_DIV_WAIT && !flush && !div_ready && wd_hit) err <= 1'b1;
        end
    end

    always_comb begin
        stallreq    = NO_STOP;
        mul_signed  = 1'b0;
        mul_ina     = '0;
        mul_inb     = '0;
        div_start   = DIV_STOP;
        div_signed  = 1'b0;
        div_opdata1 = '0;
        div_opdata2 = '0;
        div_annul   = 1'b0;
        full_we     = 1'b0;
        full_data   = '0;
        hi_we       = 1'b0;
        lo_we       = 1'b0;
        rd_hi       = 1'b0;
        mf_data     = '0;
        case (state)
            ST_IDLE: begin
                if (long_issue) stallreq = STOP;
                if (issue && op_mul) begin
                    mul_signed = is_signed_op(op);
                    mul_ina    = src1;
                    mul_inb    = src2;
                end
                if (issue && op_div && !div_zero) begin
                    div_start   = DIV_START;
                    div_signed  = is_signed_op(op);
                    div_opdata1 = src1;
                    div_opdata2 = src2;
                end
                hi_we = issue && (op == MDU_MTHI);
                lo_we = issue && (op == MDU_MTLO);
                if (issue && (op == MDU_MFHI || op == MDU_MFLO)) begin
                    rd_hi   = (op == MDU_MFHI);
                    mf_data = rdata;
                end
            end
            ST_MUL_WAIT: begin
                stallreq   = flush ? NO_STOP : STOP;
                mul_signed = opnd.sgn;
                mul_ina    = opnd.a;
                mul_inb    = opnd.b;
                if (!flush && mul_done) begin
                    full_we   = 1'b1;
                    full_data = mul_result;
                end
            end
            ST_DIV_WAIT: begin
                stallreq    = flush ? NO_STOP : STOP;
                div_signed  = opnd.sgn;
                div_opdata1 = opnd.a;
                div_opdata2 = opnd.b;
                if (flush) begin
                    div_annul = 1'b1;
                end else if (div_ready) begin
                    full_we   = 1'b1;
                    full_data = div_result;
                end else if (wd_hit) begin
                    div_annul = 1'b1;
                end else begin
                    div_start = DIV_START;
                end
            end
            default: ;
        endcase
    end

    assign mdu_err = err;

    mdu_ctrl_hilo u_hilo (
        .clk       (clk),
        .resetn    (resetn),
        .full_we   (full_we),
        .full_data (full_data),
        .hi_we     (hi_we),
        .lo_we     (lo_we),
        .wdata     (src1),
        .rd_hi     (rd_hi),
        .hi        (hi_o),
        .lo        (lo_o),
        .rdata     (rdata)
    );

endmodule

// File: tb/tb_mdu_ctrl.sv
// Directed bench for mdu_ctrl with a two-stage mul model and hand-driven div unit.
module tb_mdu_ctrl;
    import mdu_defines::*;

    logic        clk = 1'b0;
    logic        resetn, ex_valid, ex_adv, flush;
    logic [3:0]  mdu_op;
    logic [31:0] src1, src2;
    logic        stallreq, mdu_err, mul_signed, div_start, div_signed, div_annul, div_ready;
    logic [31:0] mf_data, hi_o, lo_o, mul_ina, mul_inb, div_opdata1, div_opdata2;
    logic [63:0] mul_result, div_result, p1, p2;

    int total  = 0;
    int passed = 0;
    int start_cnt;
    int annul_at;

    always #5 clk = ~clk;

    mdu_ctrl #(.MUL_LAT(2), .DIV_MAX_CYC(40)) dut (
        .clk(clk), .resetn(resetn), .ex_valid(ex_valid), .ex_adv(ex_adv), .flush(flush),
        .mdu_op(mdu_op), .src1(src1), .src2(src2), .stallreq(stallreq), .mf_data(mf_data),
        .hi_o(hi_o), .lo_o(lo_o), .mdu_err(mdu_err), .mul_signed(mul_signed),
        .mul_ina(mul_ina), .mul_inb(mul_inb), .mul_result(mul_result),
        .div_start(div_start), .div_signed(div_signed), .div_opdata1(div_opdata1),
        .div_opdata2(div_opdata2), .div_annul(div_annul), .div_ready(div_ready),
        .div_result(div_result)
    );

    // Mul unit model: result valid two cycles after operand presentation.
    always @(posedge clk) begin
        p1 <= mul_signed ? 64'($signed(mul_ina)) * 64'($signed(mul_inb))
                         : {32'b0, mul_ina} * {32'b0, mul_inb};
        p2 <= p1;
    end
    assign mul_result = p2;

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    initial begin
        resetn = 1'b0; ex_valid = 1'b0; ex_adv = 1'b0; flush = 1'b0;
        mdu_op = 4'd0; src1 = '0; src2 = '0; div_ready = 1'b0; div_result = '0;
        step(); step();
        #1;
        check("rst_stall", 64'(stallreq), 64'd0);
        check("rst_hi", 64'(hi_o), 64'd0);
        check("rst_lo", 64'(lo_o), 64'd0);
        check("rst_err", 64'(mdu_err), 64'd0);
        check("rst_divstart", 64'(div_start), 64'd0);
        check("rst_mfdata", 64'(mf_data), 64'd0);
        resetn = 1'b1;
        step();

        // MULT -2 * 3
        ex_valid = 1'b1; mdu_op = 4'(MDU_MULT); src1 = 32'hFFFF_FFFE; src2 = 32'd3;
        #1;
        check("mul_issue_stall", 64'(stallreq), 64'd1);
        check("mul_issue_ina", 64'(mul_ina), 64'hFFFF_FFFE);
        check("mul_issue_sgn", 64'(mul_signed), 64'd1);
        step();
        src1 = 32'h1111_1111; src2 = 32'h2222_2222;
        #1;
        check("mul_wait1_stall", 64'(stallreq), 64'd1);
        check("mul_wait1_ina_latched", 64'(mul_ina), 64'hFFFF_FFFE);
        step();
        #1;
        check("mul_wait2_stall", 64'(stallreq), 64'd1);
        step();
        #1;
        check("mul_done_stall", 64'(stallreq), 64'd0);
        check("mul_hi", 64'(hi_o), 64'hFFFF_FFFF);
        check("mul_lo", 64'(lo_o), 64'hFFFF_FFFA);
        step();
        #1;
        check("mul_held_no_reissue", 64'(stallreq), 64'd0);
        check("mul_held_ina", 64'(mul_ina), 64'd0);
        ex_adv = 1'b1;
        step();
        ex_adv = 1'b0; ex_valid = 1'b0;
        step();

        // DIVU 100 / 7
        ex_valid = 1'b1; mdu_op = 4'(MDU_DIVU); src1 = 32'd100; src2 = 32'd7;
        #1;
        check("divu_issue_start", 64'(div_start), 64'd1);
        check("divu_issue_stall", 64'(stallreq), 64'd1);
        check("divu_issue_op2", 64'(div_opdata2), 64'd7);
        check("divu_issue_sgn", 64'(div_signed), 64'd0);
        step();
        src1 = 32'hABCD_0000;
        start_cnt = 0;
        for (int i = 0; i < 32; i++) begin
            #1;
            if (div_start === 1'b1) start_cnt++;
            step();
        end
        check("divu_start_held", 64'(start_cnt), 64'd32);
        check("divu_op1_latched", 64'(div_opdata1), 64'd100);
        div_ready = 1'b1; div_result = {32'd2, 32'd14};
        #1;
        check("divu_ready_start_low", 64'(div_start), 64'd0);
        step();
        div_ready = 1'b0;
        #1;
        check("divu_after_stall", 64'(stallreq), 64'd0);
        check("divu_hi", 64'(hi_o), 64'd2);
        check("divu_lo", 64'(lo_o), 64'd14);
        ex_adv = 1'b1;
        step();
        ex_adv = 1'b0;

        // DIV by zero
        mdu_op = 4'(MDU_DIV); src1 = 32'd5; src2 = 32'd0;
        #1;
        check("div0_start", 64'(div_start), 64'd0);
        check("div0_stall", 64'(stallreq), 64'd0);
        step();
        #1;
        check("div0_hi", 64'(hi_o), 64'd2);
        check("div0_lo", 64'(lo_o), 64'd14);
        ex_adv = 1'b1;
        step();
        ex_adv = 1'b0;
        mdu_op = 4'(MDU_MFLO);
        #1;
        check("mflo_old", 64'(mf_data), 64'd14);
        check("mflo_stall", 64'(stallreq), 64'd0);
        step();

        // MTHI then MFHI, then flushed MTLO
        mdu_op = 4'(MDU_MTHI); src1 = 32'h1234_5678;
        #1;
        check("mthi_stall", 64'(stallreq), 64'd0);
        check("mthi_pre_edge", 64'(hi_o), 64'd2);
        step();
        #1;
        check("mthi_hi", 64'(hi_o), 64'h1234_5678);
        mdu_op = 4'(MDU_MFHI); src1 = 32'd0;
        #1;
        check("mfhi_data", 64'(mf_data), 64'h1234_5678);
        check("mfhi_stall", 64'(stallreq), 64'd0);
        step();
        mdu_op = 4'(MDU_NOP);
        #1;
        check("nop_mfdata", 64'(mf_data), 64'd0);
        step();
        mdu_op = 4'(MDU_MTLO); src1 = 32'hDEAD_BEEF; flush = 1'b1;
        step();
        flush = 1'b0;
        #1;
        check("mtlo_flushed_lo", 64'(lo_o), 64'd14);

        // DIV flushed on the div_ready cycle
        mdu_op = 4'(MDU_DIV); src1 = 32'd50; src2 = 32'd5;
        #1;
        check("div_issue_sgn", 64'(div_signed), 64'd1);
        step(); step(); step();
        div_ready = 1'b1; div_result = {32'd0, 32'd10}; flush = 1'b1;
        #1;
        check("flush_annul", 64'(div_annul), 64'd1);
        check("flush_stall", 64'(stallreq), 64'd0);
        step();
        div_ready = 1'b0; flush = 1'b0; mdu_op = 4'(MDU_MFHI);
        #1;
        check("flush_hi", 64'(hi_o), 64'h1234_5678);
        check("flush_lo", 64'(lo_o), 64'd14);
        check("flush_idle_mfhi", 64'(mf_data), 64'h1234_5678);
        step();

        // Watchdog: div_ready never arrives
        mdu_op = 4'(MDU_DIVU); src1 = 32'd1; src2 = 32'd1;
        step();
        annul_at = 0;
        for (int i = 1; i <= 60; i++) begin
            #1;
            if (div_annul === 1'b1) begin
                annul_at = i;
                break;
            end
            step();
        end
        check("wd_annul_cycle", 64'(annul_at), 64'd41);
        step();
        #1;
        check("wd_err", 64'(mdu_err), 64'd1);
        check("wd_annul_one_cycle", 64'(div_annul), 64'd0);
        check("wd_stall", 64'(stallreq), 64'd0);
        check("wd_hi", 64'(hi_o), 64'h1234_5678);
        ex_adv = 1'b1;
        step();
        ex_adv = 1'b0; ex_valid = 1'b0;
        step(); step();
        #1;
        check("wd_err_sticky", 64'(mdu_err), 64'd1);
        resetn = 1'b0;
        step();
        #1;
        check("rst2_err", 64'(mdu_err), 64'd0);
        check("rst2_hi", 64'(hi_o), 64'd0);
        check("rst2_lo", 64'(lo_o), 64'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
